// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_t;

  // Loads take B/H/W/BU/HU; stores only B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extract/extend and byte/half store merge.
import lsu_pkg::*;

module lsu_align (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase

    // Only the addressed lane(s) change; the rest of the word is written back as read.
    merge_data = word;
    if (funct3 == F3_B) begin
      case (lane)
        2'd0:    merge_data[7:0]   = wdata[7:0];
        2'd1:    merge_data[15:8]  = wdata[7:0];
        2'd2:    merge_data[23:16] = wdata[7:0];
        default: merge_data[31:24] = wdata[7:0];
      endcase
    end else if (funct3 == F3_H) begin
      if (lane[1]) merge_data[31:16] = wdata[15:0];
      else         merge_data[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide, async-read / sync-write data memory.
// Handshake: a request is taken on a posedge with req_valid && req_ready (ready only in IDLE);
// the response is a single rsp_valid pulse with no backpressure.
import lsu_pkg::*;

module load_store_unit #(
  parameter int unsigned DM_BYTES = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dm_en,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output lsu_state_t  dbg_state
);

  lsu_state_t  state, state_nx;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, merge_q;
  logic        accept, acc_err, misaligned, out_of_range;
  logic [31:0] load_data, merge_data;

  assign accept = req_valid && req_ready;

  always_comb begin
    misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >= DM_BYTES);
    acc_err = misaligned || out_of_range || !f3_legal(req_we, req_funct3);
  end

  lsu_align u_align (
    .word       (dm_rdata),
    .lane       (addr_q[1:0]),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req_valid) state_nx = acc_err ? RESP : EXEC;
      EXEC:     state_nx = (we_q && (f3_q != F3_W)) ? MERGE_WR : RESP;
      MERGE_WR: state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Request capture and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      err_q   <= acc_err;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == EXEC) begin
      if (!we_q)              rdata_q <= load_data;
      else if (f3_q != F3_W)  merge_q <= merge_data;
    end
  end

  // Outputs
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = (state == RESP) ? rdata_q : '0;
    rsp_err   = (state == RESP) && err_q;
    dm_en     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    case (state)
      EXEC: begin
        dm_addr = {addr_q[31:2], 2'b00};
        if (we_q && (f3_q == F3_W)) begin
          dm_en    = 1'b1;
          dm_wdata = wdata_q;
        end
      end
      MERGE_WR: begin
        dm_addr  = {addr_q[31:2], 2'b00};
        dm_en    = 1'b1;
        dm_wdata = merge_q;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit paired with a 1000-word data memory model and a response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, dm_en;
  logic [31:0] rsp_rdata, dm_addr, dm_wdata, dm_rdata;
  lsu_state_t  dbg_state;

  always #5 clk = ~clk;

  load_store_unit #(.DM_BYTES(4000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_en      (dm_en),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dbg_state  (dbg_state)
  );

  // Data memory model with a backdoor preload port
  logic [31:0] mem [0:999];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [29:0] widx;

  assign widx     = dm_addr[31:2];
  assign dm_rdata = (widx < 30'd1000) ? mem[widx[9:0]] : '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (dm_en && (widx < 30'd1000)) mem[widx[9:0]] <= dm_wdata;
  end

  int acc_cnt = 0;
  int en_cnt  = 0;
  always @(posedge clk) begin
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (dm_en) en_cnt <= en_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];
  int           exp_en_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = idx[9:0];
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive one request, keep req_valid high until the response, then score it.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input int n_en);
    int a0, e0, cyc;
    logic got;
    exp_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    exp_lat_q.push_back(lat);
    exp_en_q.push_back(n_en);
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    a0 = acc_cnt;
    e0 = en_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) got = 1'b1;
      else check("busy_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    check("rsp_seen", {31'd0, got}, 32'd1);
    check("rdata", rsp_rdata, exp_q.pop_front());
    check("err", {31'd0, rsp_err}, {31'd0, exp_err_q.pop_front()});
    check("latency", cyc, exp_lat_q.pop_front());
    check("accepts", acc_cnt - a0, 32'd1);
    check("dm_en_cycles", en_cnt - e0, exp_en_q.pop_front());
  endtask

  initial begin
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [1:0]  lo;
    int          wi;

    f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W;
    f3_tab[3] = F3_BU; f3_tab[4] = F3_HU;

    #3;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_dm_en", {31'd0, dm_en}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);

    for (int i = 0; i < 8; i++) preload(i, $urandom);
    preload(1, 32'h8899AABB);
    preload(2, 32'h11223344);
    preload(3, 32'h55667788);
    preload(999, 32'hCAFEF00D);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads from mem[1]
    do_req(1'b0, F3_B,  32'd6, 32'd0, 32'hFFFFFF99, 1'b0, 2, 0);
    do_req(1'b0, F3_HU, 32'd6, 32'd0, 32'h00008899, 1'b0, 2, 0);
    do_req(1'b0, F3_H,  32'd4, 32'd0, 32'hFFFFAABB, 1'b0, 2, 0);
    do_req(1'b0, F3_W,  32'd4, 32'd0, 32'h8899AABB, 1'b0, 2, 0);
    do_req(1'b0, F3_BU, 32'd7, 32'd0, 32'h00000088, 1'b0, 2, 0);
    do_req(1'b0, F3_B,  32'd4, 32'd0, 32'hFFFFFFBB, 1'b0, 2, 0);
    do_req(1'b0, F3_W,  32'd3996, 32'd0, 32'hCAFEF00D, 1'b0, 2, 0);

    // Byte/half stores by read-modify-write, full-word store
    do_req(1'b1, F3_B, 32'd9, 32'hAAAAAAEE, 32'd0, 1'b0, 3, 1);
    check("mem2_sb", mem[2], 32'h1122EE44);
    do_req(1'b1, F3_H, 32'd10, 32'h1234CAFE, 32'd0, 1'b0, 3, 1);
    check("mem2_sh", mem[2], 32'hCAFEEE44);
    do_req(1'b0, F3_W, 32'd8, 32'd0, 32'hCAFEEE44, 1'b0, 2, 0);
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1);
    check("mem4_sw", mem[4], 32'hDEADBEEF);

    // Error requests: no memory write, latency 1
    do_req(1'b0, F3_W,  32'd6,    32'd0, 32'd0, 1'b1, 1, 0);
    do_req(1'b1, F3_H,  32'd3,    32'd0, 32'd0, 1'b1, 1, 0);
    do_req(1'b0, F3_W,  32'd4000, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req(1'b0, 3'b011, 32'd0,   32'd0, 32'd0, 1'b1, 1, 0);
    do_req(1'b1, F3_BU, 32'd0,    32'hFF, 32'd0, 1'b1, 1, 0);
    do_req(1'b0, F3_HU, 32'd5,    32'd0, 32'd0, 1'b1, 1, 0);

    // Random legal loads over preloaded words
    for (int i = 0; i < 12; i++) begin
      wi = $urandom_range(0, 7);
      f3 = f3_tab[$urandom_range(0, 4)];
      lo = 2'($urandom_range(0, 3));
      if (f3 == F3_H || f3 == F3_HU) lo[0] = 1'b0;
      if (f3 == F3_W) lo = 2'b00;
      do_req(1'b0, f3, 32'(wi * 4) + {30'd0, lo}, 32'd0, ld_model(mem[wi], lo, f3), 1'b0, 2, 0);
    end

    // Reset in the middle of a merged byte store
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'd12;
    req_wdata  = 32'h000000FF;
    @(negedge clk);
    @(negedge clk);
    check("mid_state", {30'd0, dbg_state}, {30'd0, MERGE_WR});
    check("mid_dm_en", {31'd0, dm_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    req_valid = 1'b0;
    check("abort_dm_en", {31'd0, dm_en}, 32'd0);
    check("abort_dm_addr", dm_addr, 32'd0);
    check("abort_dm_wdata", dm_wdata, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'd0);
    check("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_mem3", mem[3], 32'h55667788);
    @(negedge clk);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Unit keeps working after the aborted store
    do_req(1'b0, F3_W, 32'd12, 32'd0, 32'h55667788, 1'b0, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
